// File: rtl/call_stack_if.sv
// Decoder/pc-side bundle for the return-address stack: request strobes in,
// registered load/address and status out.
interface call_stack_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             call;
   logic             ret;
   logic [WIDTH-1:0] crnt_adr;
   logic [WIDTH-1:0] tgt_adr;
   logic             clr_err;
   logic             load;
   logic [WIDTH-1:0] nxt_adr;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic [2:0]       err;

   modport master (
      output call, ret, crnt_adr, tgt_adr, clr_err,
      input  load, nxt_adr, empty, full, count, err
   );

   modport slave (
      input  call, ret, crnt_adr, tgt_adr, clr_err,
      output load, nxt_adr, empty, full, count, err
   );
endinterface

// File: rtl/call_stack.sv
// Hardware return-address stack: a call pushes crnt_adr+1 and redirects the pc,
// a return pops the saved address back into it. All outputs are registered.
module call_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   call_stack_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             load_q, load_d;
   logic [WIDTH-1:0] nxt_adr_q, nxt_adr_d;
   logic [2:0]       err_q, err_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             push;
   logic [WIDTH-1:0] push_adr;
   logic [WIDTH-1:0] pop_adr;

   always_comb begin
      count_d   = count_q;
      load_d    = 1'b0;
      nxt_adr_d = nxt_adr_q;
      err_d     = err_q;
      push      = 1'b0;
      push_adr  = bus.crnt_adr + 1'b1;
      pop_adr   = '0;
      // Entry count_q-1 is the top of stack; a loop avoids a mis-sized array index.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (count_q == CW'(i + 1)) pop_adr = stack_q[i];
      end

      if (bus.call && bus.ret) begin
         err_d[2] = 1'b1;
      end else if (bus.call) begin
         if (!full_q) begin
            push      = 1'b1;
            count_d   = count_q + 1'b1;
            load_d    = 1'b1;
            nxt_adr_d = bus.tgt_adr;
         end else begin
            err_d[0] = 1'b1;
         end
      end else if (bus.ret) begin
         if (!empty_q) begin
            count_d   = count_q - 1'b1;
            load_d    = 1'b1;
            nxt_adr_d = pop_adr;
         end else begin
            err_d[1] = 1'b1;
         end
      end

      if (bus.clr_err) err_d = '0;

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= '0;
         load_q    <= 1'b0;
         nxt_adr_q <= '0;
         err_q     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         load_q    <= load_d;
         nxt_adr_q <= nxt_adr_d;
         err_q     <= err_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
      end
   end

   // Entry contents need no reset; only count decides what is valid.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push && count_q == CW'(i)) stack_q[i] <= push_adr;
      end
   end

   assign bus.load    = load_q;
   assign bus.nxt_adr = nxt_adr_q;
   assign bus.count   = count_q;
   assign bus.err     = err_q;
   assign bus.empty   = empty_q;
   assign bus.full    = full_q;
endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack (WIDTH=8, DEPTH=4) with hand-computed
// expectations checked by immediate assertions.
module tb_call_stack;
   logic clk;
   logic reset;
   int unsigned total;
   int unsigned bad;

   call_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

   call_stack #(.WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic c, input logic r, input logic [7:0] crnt,
                        input logic [7:0] tgt, input logic clr);
      bus.call     = c;
      bus.ret      = r;
      bus.crnt_adr = crnt;
      bus.tgt_adr  = tgt;
      bus.clr_err  = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("rst_load",  32'(bus.load),    32'h0);
      chk("rst_nxt",   32'(bus.nxt_adr), 32'h0);
      chk("rst_count", 32'(bus.count),   32'h0);
      chk("rst_empty", 32'(bus.empty),   32'h1);
      chk("rst_full",  32'(bus.full),    32'h0);
      chk("rst_err",   32'(bus.err),     32'h0);

      // single call / return
      drive(1'b1, 1'b0, 8'h10, 8'h40, 1'b0); tick();
      chk("call_load",  32'(bus.load),    32'h1);
      chk("call_nxt",   32'(bus.nxt_adr), 32'h40);
      chk("call_count", 32'(bus.count),   32'h1);
      chk("call_empty", 32'(bus.empty),   32'h0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); tick();
      chk("idle_load", 32'(bus.load),    32'h0);
      chk("idle_nxt",  32'(bus.nxt_adr), 32'h40);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); tick();
      chk("ret_load",  32'(bus.load),    32'h1);
      chk("ret_nxt",   32'(bus.nxt_adr), 32'h11);
      chk("ret_empty", 32'(bus.empty),   32'h1);

      // fill, overflow, drain (back-to-back)
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'(i), 8'(8'h80 + i), 1'b0); tick();
         chk("fill_load", 32'(bus.load),    32'h1);
         chk("fill_nxt",  32'(bus.nxt_adr), 32'(8'h80 + i));
      end
      chk("full_flag",  32'(bus.full),  32'h1);
      chk("full_count", 32'(bus.count), 32'h4);
      drive(1'b1, 1'b0, 8'h55, 8'h66, 1'b0); tick();
      chk("ovf_load",  32'(bus.load),    32'h0);
      chk("ovf_err",   32'(bus.err),     32'h1);
      chk("ovf_count", 32'(bus.count),   32'h4);
      chk("ovf_nxt",   32'(bus.nxt_adr), 32'h83);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); tick();
         chk("drain_load", 32'(bus.load),    32'h1);
         chk("drain_nxt",  32'(bus.nxt_adr), 32'(4 - i));
      end
      chk("drain_empty", 32'(bus.empty), 32'h1);
      chk("drain_full",  32'(bus.full),  32'h0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1); tick();
      chk("clr_ovf", 32'(bus.err), 32'h0);

      // underflow, then clear
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); tick();
      chk("unf_load", 32'(bus.load),    32'h0);
      chk("unf_err",  32'(bus.err),     32'h2);
      chk("unf_nxt",  32'(bus.nxt_adr), 32'h01);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1); tick();
      chk("clr_unf", 32'(bus.err), 32'h0);

      // call+ret conflict
      drive(1'b1, 1'b0, 8'h20, 8'h30, 1'b0); tick();
      chk("pre_conf_count", 32'(bus.count), 32'h1);
      drive(1'b1, 1'b1, 8'h70, 8'h71, 1'b0); tick();
      chk("conf_load",  32'(bus.load),  32'h0);
      chk("conf_count", 32'(bus.count), 32'h1);
      chk("conf_err",   32'(bus.err),   32'h4);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b1); tick();
      chk("conf_ret_nxt", 32'(bus.nxt_adr), 32'h21);
      chk("conf_clr",     32'(bus.err),     32'h0);
      // clear wins over same-cycle underflow
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b1); tick();
      chk("clr_wins_err",  32'(bus.err),  32'h0);
      chk("clr_wins_load", 32'(bus.load), 32'h0);

      // increment wrap
      drive(1'b1, 1'b0, 8'hFF, 8'h05, 1'b0); tick();
      chk("wrap_call_nxt", 32'(bus.nxt_adr), 32'h05);
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); tick();
      chk("wrap_ret_load", 32'(bus.load),    32'h1);
      chk("wrap_ret_nxt",  32'(bus.nxt_adr), 32'h00);

      // asynchronous reset mid-run
      drive(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); tick();
      chk("pre_rst_err", 32'(bus.err), 32'h2);
      drive(1'b1, 1'b0, 8'h30, 8'h60, 1'b0); tick();
      chk("pre_rst_load", 32'(bus.load), 32'h1);
      reset = 1'b0;
      #2;
      chk("arst_load",  32'(bus.load),    32'h0);
      chk("arst_count", 32'(bus.count),   32'h0);
      chk("arst_empty", 32'(bus.empty),   32'h1);
      chk("arst_err",   32'(bus.err),     32'h0);
      chk("arst_nxt",   32'(bus.nxt_adr), 32'h0);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      reset = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
